// File: rtl/mem_pkg.sv
// Shared types and helpers for the block memory slave: transaction codes,
// read-slot record and the flush-match function.
package mem_pkg;

  localparam logic [7:0] TRSC_GETI = 8'd0;
  localparam logic [7:0] TRSC_GETV = 8'd1;

  typedef struct packed {
    logic        valid;
    logic [7:0]  rqst;
    logic [63:0] addr;
    logic [7:0]  timer;
  } slot_t;

  // An ID is flushed when it is nonzero and agrees with flrqst on every unmasked bit.
  function automatic logic fl(input logic [7:0] x, input logic [7:0] mask, input logic [7:0] rqst);
    return (|x) && ((x & ~mask) == (rqst & ~mask));
  endfunction

endpackage

// File: rtl/blkmem_slave_firstk.sv
// Selects the lowest K set bits of a vector as a mask; used with K=1 as a
// lowest-index one-hot picker for free and ready read slots.
module firstk #(
  parameter int WIDTH = 4,
  parameter int K     = 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [WIDTH-1:0] sel
);

  int cnt;

  always_comb begin
    sel = '0;
    cnt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i] && cnt < K) begin
        sel[i] = 1'b1;
        cnt    = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/blkmem_slave.sv
// Block-granular backing memory with split-transaction line reads.
// Optional BLKMEM_RANDLAT_EN adds LFSR jitter (0..3 cycles) to each read's latency.
module blkmem_slave
  import mem_pkg::*;
#(
  parameter int         blk   = 64,
  parameter int         depth = 1024,
  parameter int         lat   = 4,
  parameter int         qsz   = 4,
  parameter logic [7:0] hbase = 8'hf8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         flmask,
  input  logic [7:0]         flrqst,
  input  logic [7:0]         s_rqst,
  input  logic [7:0]         s_trsc,
  input  logic [blk-1:0]     s_strb,
  input  logic [63:0]        s_addr,
  input  logic [blk*8-1:0]   s_wdat,
  output logic [7:0]         s_resp,
  output logic [7:0]         s_miss,
  output logic [63:0]        s_ofst,
  output logic [blk*8-1:0]   s_rdat
);

  localparam int OW = $clog2(blk);
  localparam int IW = $clog2(depth);
  localparam int QW = (qsz > 1) ? $clog2(qsz) : 1;

  // depth is a power of two, so the line index is a plain address slice
  logic [blk*8-1:0] mem [depth];
  slot_t            slot [qsz];

  logic [qsz-1:0] valid, flushed, ready, match, free_nxt, rdy_sel, free_sel;
  logic [QW-1:0]  rdy_idx, free_idx, hit_idx;
  logic           complete, req_ok, is_getv, is_geti, hit, alloc, mem_we;
  logic [7:0]     new_timer;

  // A slot completes on the edge where its timer reaches zero (or later if outranked).
  always_comb begin
    valid   = '0;
    flushed = '0;
    ready   = '0;
    match   = '0;
    for (int k = 0; k < qsz; k++) begin
      valid[k]   = slot[k].valid;
      flushed[k] = slot[k].valid &&
                   (fl(slot[k].rqst, flmask, flrqst) || fl(hbase | 8'(k), flmask, flrqst));
      ready[k]   = slot[k].valid && !flushed[k] && (slot[k].timer <= 8'd1);
      match[k]   = slot[k].valid && !flushed[k] && (slot[k].rqst == s_rqst) &&
                   (slot[k].addr[63:OW] == s_addr[63:OW]);
    end
  end

  firstk #(.WIDTH(qsz), .K(1)) u_rdy_pick  (.vec(ready),    .sel(rdy_sel));
  firstk #(.WIDTH(qsz), .K(1)) u_free_pick (.vec(free_nxt), .sel(free_sel));

  assign free_nxt = ~valid | flushed | rdy_sel;

  always_comb begin
    rdy_idx  = '0;
    free_idx = '0;
    hit_idx  = '0;
    for (int k = qsz - 1; k >= 0; k--) begin
      if (rdy_sel[k])  rdy_idx  = QW'(k);
      if (free_sel[k]) free_idx = QW'(k);
      if (match[k])    hit_idx  = QW'(k);
    end
  end

  assign complete = |ready;
  assign req_ok   = (s_rqst != 8'd0) && !fl(s_rqst, flmask, flrqst) && !complete;
  assign is_getv  = (s_trsc == TRSC_GETV);
  assign is_geti  = (s_trsc == TRSC_GETI);
  assign hit      = |match;
  assign alloc    = req_ok && is_getv && !hit && (|free_nxt);
  assign mem_we   = req_ok && is_geti && !rst;

`ifdef BLKMEM_RANDLAT_EN
  logic [7:0] lfsr;

  assign new_timer = 8'(lat) + {6'd0, lfsr[1:0]};

  // x^8+x^6+x^5+x^4+1, advanced once per slot allocation
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        lfsr <= 8'h01;
    else if (alloc) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
`else
  assign new_timer = 8'(lat);
`endif

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < blk; i++) begin
        if (s_strb[i]) mem[s_addr[OW+IW-1:OW]][i*8 +: 8] <= s_wdat[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_resp <= '0;
      s_miss <= '0;
      s_ofst <= '0;
      s_rdat <= '0;
      for (int k = 0; k < qsz; k++) slot[k] <= '0;
    end else begin
      s_resp <= '0;
      s_miss <= '0;
      for (int k = 0; k < qsz; k++) begin
        if (flushed[k] || rdy_sel[k])
          slot[k].valid <= 1'b0;
        else if (slot[k].valid && slot[k].timer != 8'd0)
          slot[k].timer <= slot[k].timer - 8'd1;
      end
      if (complete) begin
        s_resp <= hbase | 8'(rdy_idx);
        s_ofst <= slot[rdy_idx].addr;
        s_rdat <= mem[slot[rdy_idx].addr[OW+IW-1:OW]];
      end else if (req_ok) begin
        if (!is_getv) begin
          s_resp <= s_rqst;
          s_ofst <= s_addr;
        end else if (hit) begin
          s_resp <= s_rqst;
          s_miss <= hbase | 8'(hit_idx);
          s_ofst <= s_addr;
        end else if (alloc) begin
          slot[free_idx] <= '{valid: 1'b1, rqst: s_rqst, addr: s_addr, timer: new_timer};
          s_resp <= s_rqst;
          s_miss <= hbase | 8'(free_idx);
          s_ofst <= s_addr;
        end
      end
    end
  end

endmodule
